// File: rtl/mon_s2cif.sv
// mon_s2cif: output-side monitor. Samples a 1-bit DUT output while enabled,
// packs the bits LSB-first into WORD_W-bit words, buffers completed words in a
// DEPTH-entry FIFO and hands them to the scenario side on request.
module mon_s2cif #(
   parameter int id     = 0,
   parameter int WORD_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         mon_en,
   input  logic                         din,
   input  logic                         flush,
   input  logic                         rd_req,
   output logic                         rd_valid,
   output logic [WORD_W-1:0]            rd_data,
   output logic                         rd_nodata,
   output logic [7:0]                   rd_id,
   output logic [$clog2(DEPTH):0]       level,
   output logic [$clog2(WORD_W):0]      bit_cnt,
   output logic                         overflow,
   output logic [15:0]                  drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(WORD_W) + 1;

   typedef enum logic [0:0] {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_t;

   rd_state_t         rd_state_r;
   logic [WORD_W-1:0] shift_r;
   logic [BW-1:0]     bit_cnt_r;
   logic [WORD_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wptr_r;
   logic [AW-1:0]     rptr_r;
   logic [LW-1:0]     level_r;
   logic              rd_valid_r;
   logic              rd_nodata_r;
   logic [WORD_W-1:0] rd_data_r;
   logic              overflow_r;
   logic [15:0]       drop_cnt_r;

   logic [WORD_W-1:0] word_s;
   logic [BW-1:0]     cnt_eff_s;
   logic              word_done_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              accept_s;
   logic              drop_s;

   // Merge the bit sampled this edge into the partial word and count it.
   always_comb begin
      word_s    = shift_r;
      cnt_eff_s = bit_cnt_r;
      if (mon_en) begin
         word_s[bit_cnt_r[BW-2:0]] = din;
         cnt_eff_s                 = bit_cnt_r + BW'(1);
      end else begin
         word_s    = shift_r;
         cnt_eff_s = bit_cnt_r;
      end
   end

   // A natural completion and a flush at the same edge produce a single push;
   // a pop frees a slot before the push is judged against full.
   assign word_done_s = mon_en && (bit_cnt_r == BW'(WORD_W - 1));
   assign push_s      = word_done_s || (flush && (cnt_eff_s != BW'(0)));
   assign pop_s       = rd_req && (level_r != LW'(0));
   assign full_s      = (level_r == LW'(DEPTH));
   assign accept_s    = push_s && (!full_s || pop_s);
   assign drop_s      = push_s && full_s && !pop_s;

   // Bit packer: shift register and partial-word bit count.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r   <= {WORD_W{1'b0}};
         bit_cnt_r <= BW'(0);
      end else if (push_s) begin
         shift_r   <= {WORD_W{1'b0}};
         bit_cnt_r <= BW'(0);
      end else if (mon_en) begin
         shift_r   <= word_s;
         bit_cnt_r <= cnt_eff_s;
      end else begin
         shift_r   <= shift_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wptr_r] <= word_s;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_r  <= AW'(0);
         rptr_r  <= AW'(0);
         level_r <= LW'(0);
      end else begin
         if (accept_s) begin
            wptr_r <= wptr_r + AW'(1);
         end
         if (pop_s) begin
            rptr_r <= rptr_r + AW'(1);
         end
         case ({accept_s, pop_s})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Read FSM: every request gets exactly one response pulse the next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_r  <= RD_IDLE;
         rd_valid_r  <= 1'b0;
         rd_nodata_r <= 1'b0;
         rd_data_r   <= {WORD_W{1'b0}};
      end else begin
         case (rd_state_r)
            RD_IDLE, RD_RESP: begin
               if (rd_req) begin
                  rd_state_r  <= RD_RESP;
                  rd_valid_r  <= pop_s;
                  rd_nodata_r <= !pop_s;
                  if (pop_s) begin
                     rd_data_r <= mem_r[rptr_r];
                  end
               end else begin
                  rd_state_r  <= RD_IDLE;
                  rd_valid_r  <= 1'b0;
                  rd_nodata_r <= 1'b0;
               end
            end
            default: begin
               rd_state_r  <= RD_IDLE;
               rd_valid_r  <= 1'b0;
               rd_nodata_r <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overflow flag and saturating dropped-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_r <= 1'b0;
         drop_cnt_r <= 16'h0000;
      end else if (drop_s) begin
         overflow_r <= 1'b1;
         if (drop_cnt_r != 16'hFFFF) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
         end
      end else begin
         overflow_r <= overflow_r;
         drop_cnt_r <= drop_cnt_r;
      end
   end

   assign rd_valid  = rd_valid_r;
   assign rd_nodata = rd_nodata_r;
   assign rd_data   = rd_data_r;
   assign rd_id     = 8'(id);
   assign level     = level_r;
   assign bit_cnt   = bit_cnt_r;
   assign overflow  = overflow_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_mon_s2cif.sv
// tb_mon_s2cif: table-driven vectors plus hand sequences for mon_s2cif with a
// reference FIFO model and a response scoreboard.
module tb_mon_s2cif;

   logic        clk = 1'b0;
   logic        rst, mon_en, din, flush, rd_req;
   logic        rd_valid, rd_nodata, overflow;
   logic [7:0]  rd_data, rd_id;
   logic [4:0]  level;
   logic [3:0]  bit_cnt;
   logic [15:0] drop_cnt;

   mon_s2cif #(.id(0), .WORD_W(8), .DEPTH(16)) dut (
      .clk(clk), .rst(rst), .mon_en(mon_en), .din(din), .flush(flush),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
      .rd_nodata(rd_nodata), .rd_id(rd_id), .level(level), .bit_cnt(bit_cnt),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic nodata;
      logic [7:0] data;
   } resp_t;

   typedef struct {
      logic en; logic d; logic fl; logic rq;
      int lvl; int cnt; int xd;
   } vec_t;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [7:0]  mq[$];
   resp_t       exp_q[$];
   int          m_cnt = 0;
   logic [7:0]  m_sh = 8'h00;
   int          m_drop = 0;
   logic        m_ovf = 1'b0;
   logic [7:0]  m_last = 8'h00;
   vec_t        tbl[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic mpush(input logic [7:0] w);
      if (mq.size() < 16) mq.push_back(w);
      else begin
         m_ovf = 1'b1;
         if (m_drop < 65535) m_drop++;
      end
   endtask

   // One clock: model the edge, drive inputs, then check DUT against the model.
   task automatic step(input logic en, input logic d, input logic fl, input logic rq);
      resp_t r;
      mon_en = en; din = d; flush = fl; rd_req = rq;
      if (rq) begin
         if (mq.size() > 0) begin
            m_last = mq.pop_front();
            exp_q.push_back('{1'b0, m_last});
         end else begin
            exp_q.push_back('{1'b1, m_last});
         end
      end
      if (en) begin
         m_sh[m_cnt] = d;
         m_cnt++;
      end
      if (m_cnt == 8 || (fl && m_cnt > 0)) begin
         mpush(m_sh);
         m_sh = 8'h00;
         m_cnt = 0;
      end
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         chk("rd_valid", 32'(rd_valid), 32'(!r.nodata));
         chk("rd_nodata", 32'(rd_nodata), 32'(r.nodata));
         chk("rd_data", 32'(rd_data), 32'(r.data));
      end else begin
         chk("idle_valid", 32'(rd_valid), 32'd0);
         chk("idle_nodata", 32'(rd_nodata), 32'd0);
      end
      chk("level", 32'(level), 32'(mq.size()));
      chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      mon_en = 1'b0; din = 1'b0; flush = 1'b0; rd_req = 1'b0;
   endtask

   task automatic put_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) step(1'b1, w[i], 1'b0, 1'b0);
   endtask

   task automatic do_reset(input logic rq);
      rst = 1'b1; rd_req = rq; mon_en = 1'b1; din = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; rd_req = 1'b0; mon_en = 1'b0; din = 1'b0;
      mq.delete(); exp_q.delete();
      m_cnt = 0; m_sh = 8'h00; m_drop = 0; m_ovf = 1'b0; m_last = 8'h00;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_nodata", 32'(rd_nodata), 32'd0);
      chk("rst_data", 32'(rd_data), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_id", 32'(rd_id), 32'd0);
   endtask

   initial begin
      rst = 1'b1; mon_en = 1'b0; din = 1'b0; flush = 1'b0; rd_req = 1'b0;
      @(posedge clk); #1;
      do_reset(1'b0);

      // en, din, flush, rd_req -> level, bit_cnt, rd_data (-1 = not checked)
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, -1};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, -1};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 3, -1};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 4, -1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 5, -1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 6, -1};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 7, -1};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 0, -1};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 8'h4D};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, -1};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, -1};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 3, -1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, -1};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 0, -1};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 8'h07};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 8'h07};
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].en, tbl[i].d, tbl[i].fl, tbl[i].rq);
         chk("tbl_level", 32'(level), 32'(tbl[i].lvl));
         chk("tbl_bit_cnt", 32'(bit_cnt), 32'(tbl[i].cnt));
         if (tbl[i].xd >= 0) chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].xd));
      end
      chk("tbl_empty_nodata", 32'(rd_nodata), 32'd1);

      // Enable gap holds the partial word.
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         chk("gap_bit_cnt", 32'(bit_cnt), 32'd4);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("gap_level", 32'(level), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("gap_word", 32'(rd_data), 32'h0F);

      // Flush counts a bit sampled at the same edge.
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("flush_same_level", 32'(level), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("flush_same_word", 32'(rd_data), 32'h07);

      // Natural completion at the flush edge pushes once.
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("flush_full_level", 32'(level), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("flush_full_word", 32'(rd_data), 32'hFF);

      // Push and pop at level 0: pop sees empty, push is stored.
      begin
         logic [7:0] w;
         w = 8'h5A;
         for (int i = 0; i < 7; i++) step(1'b1, w[i], 1'b0, 1'b0);
         step(1'b1, w[7], 1'b0, 1'b1);
         chk("pp0_nodata", 32'(rd_nodata), 32'd1);
         chk("pp0_level", 32'(level), 32'd1);
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("pp0_word", 32'(rd_data), 32'h5A);
      end

      // Overflow: 18 words into 16 slots.
      for (int w = 0; w < 18; w++) put_word(8'(w));
      chk("ovf_flag", 32'(overflow), 32'd1);
      chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
      chk("ovf_level", 32'(level), 32'd16);
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("ovf_order", 32'(rd_data), 32'(k));
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovf_17th_nodata", 32'(rd_nodata), 32'd1);
      chk("ovf_17th_hold", 32'(rd_data), 32'h0F);

      // Full FIFO with pop and push at the same edge.
      for (int w = 8'h20; w < 8'h30; w++) put_word(8'(w));
      begin
         logic [7:0] w;
         w = 8'h30;
         for (int i = 0; i < 7; i++) step(1'b1, w[i], 1'b0, 1'b0);
         step(1'b1, w[7], 1'b0, 1'b1);
      end
      chk("fullpp_level", 32'(level), 32'd16);
      chk("fullpp_drop", 32'(drop_cnt), 32'd2);
      chk("fullpp_head", 32'(rd_data), 32'h20);
      for (int k = 8'h21; k <= 8'h30; k++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("fullpp_order", 32'(rd_data), 32'(k));
      end

      // Reset mid-word and mid-read.
      for (int w = 8'h40; w < 8'h45; w++) put_word(8'(w));
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(level), 32'd5);
      chk("pre_rst_bit_cnt", 32'(bit_cnt), 32'd3);
      do_reset(1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_nodata", 32'(rd_nodata), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
